// File: rtl/updn_counter_pkg.sv
// Shared constants and types for the modulo up/down counter.
package updn_counter_pkg;

  // Direction encoding on up_down
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Limit handling encoding on sat_mode
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Operation chosen for the coming clock edge
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,  // no load, no enable
    OP_LOAD  = 3'd1,  // parallel load (clamped to mod_max)
    OP_INC   = 3'd2,  // plain increment
    OP_DEC   = 3'd3,  // plain decrement
    OP_OVF   = 3'd4,  // up count at/above the upper limit
    OP_UDF   = 3'd5,  // down count at zero
    OP_CLAMP = 3'd6   // down count while above a lowered mod_max
  } op_e;

endpackage : updn_counter_pkg

// File: rtl/updn_next_state.sv
// Combinational next-count, terminal-count and flag-set logic.
// Holds no state; every flop lives in updn_counter_mod.
module updn_next_state
  import updn_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             en_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] mod_max_i,
  input  logic             sat_mode_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             tc_set_o,
  output logic             ovf_set_o,
  output logic             udf_set_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  op_e op_s;

  // Limit a loaded value to the current upper count limit
  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] val,
                                                    input logic [WIDTH-1:0] max);
    return (val > max) ? max : val;
  endfunction

  // Pick the operation: load beats enable, enable=0 holds
  always_comb begin
    op_s = OP_HOLD;
    if (load_i) begin
      op_s = OP_LOAD;
    end else if (en_i) begin
      case (up_down_i)
        DIR_UP: begin
          if (q_i >= mod_max_i) begin
            op_s = OP_OVF;
          end else begin
            op_s = OP_INC;
          end
        end
        DIR_DOWN: begin
          // A Q stranded above a lowered limit is pulled back silently
          if (q_i > mod_max_i) begin
            op_s = OP_CLAMP;
          end else if (q_i == ZERO) begin
            op_s = OP_UDF;
          end else begin
            op_s = OP_DEC;
          end
        end
        default: op_s = OP_HOLD;
      endcase
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Produce next count and the one-shot event strobes for the chosen op
  always_comb begin
    q_next_o  = q_i;
    tc_set_o  = 1'b0;
    ovf_set_o = 1'b0;
    udf_set_o = 1'b0;
    case (op_s)
      OP_HOLD:  q_next_o = q_i;
      OP_LOAD:  q_next_o = clamp_to_max(load_val_i, mod_max_i);
      OP_INC:   q_next_o = q_i + ONE;
      OP_DEC:   q_next_o = q_i - ONE;
      OP_OVF: begin
        case (sat_mode_i)
          MODE_SAT:  q_next_o = mod_max_i;
          MODE_WRAP: q_next_o = ZERO;
          default:   q_next_o = ZERO;
        endcase
        tc_set_o  = 1'b1;
        ovf_set_o = 1'b1;
      end
      OP_UDF: begin
        case (sat_mode_i)
          MODE_SAT:  q_next_o = ZERO;
          MODE_WRAP: q_next_o = mod_max_i;
          default:   q_next_o = mod_max_i;
        endcase
        tc_set_o  = 1'b1;
        udf_set_o = 1'b1;
      end
      OP_CLAMP: q_next_o = mod_max_i;
      default:  q_next_o = q_i;
    endcase
  end

endmodule : updn_next_state

// File: rtl/updn_counter_mod.sv
// Modulo up/down counter with load, wrap/saturate limits, a one-cycle
// terminal-count pulse and sticky overflow/underflow flags.
module updn_counter_mod
  import updn_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_set_s, udf_set_s;

  updn_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i        (q_q),
    .en_i       (en),
    .up_down_i  (up_down),
    .load_i     (load),
    .load_val_i (load_val),
    .mod_max_i  (mod_max),
    .sat_mode_i (sat_mode),
    .q_next_o   (q_d),
    .tc_set_o   (tc_d),
    .ovf_set_o  (ovf_set_s),
    .udf_set_o  (udf_set_s)
  );

  // Sticky flags: a new event in the same cycle outranks the clear
  always_comb begin
    ovf_d = ovf_set_s | (ovf_q & ~clr_flags);
    udf_d = udf_set_s | (udf_q & ~clr_flags);
  end

  // State registers; reset takes effect immediately, independent of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RESET_Q;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule : updn_counter_mod
